// File: rtl/pipeline_pkg.sv
// Shared data-memory encodings and width constants for the load/store path.
package pipeline_pkg;

  localparam int XLEN      = 32;
  localparam int DM_TYPE_W = 3;

  typedef enum logic [DM_TYPE_W-1:0] {
    DM_BYTE   = 3'b000,
    DM_HALF   = 3'b001,
    DM_WORD   = 3'b010,
    DM_BYTE_U = 3'b100,
    DM_HALF_U = 3'b101
  } dm_type_e;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DBG = 1'b1
  } dm_owner_e;

  // Counter width able to hold 0..max_wait inclusive.
  function automatic int unsigned wait_cnt_w(input int unsigned max_wait);
    return (max_wait < 1) ? 1 : $clog2(max_wait + 1);
  endfunction

endpackage

// File: rtl/dm_arb_pick.sv
// Fixed-priority grant decision: CPU first, debug when CPU is idle or starved debug is forced.
module dm_arb_pick
  import pipeline_pkg::*;
(
  input  logic cpu_req_i,
  input  logic dbg_req_i,
  input  logic force_i,
  output logic cpu_gnt_o,
  output logic dbg_gnt_o
);

  always_comb begin
    dbg_gnt_o = dbg_req_i & (force_i | ~cpu_req_i);
    cpu_gnt_o = cpu_req_i & ~dbg_gnt_o;
  end

endmodule

// File: rtl/dm_arbiter.sv
// Two-port (CPU / debug) data-memory arbiter: grant in N, memory access in N+1, read response in N+2.
module dm_arbiter
  import pipeline_pkg::*;
#(
  parameter int DBG_WAIT_MAX = 8,
  parameter int AW           = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cpu_req,
  input  logic                 cpu_we,
  input  logic [AW-1:0]        cpu_addr,
  input  logic [AW-1:0]        cpu_wdata,
  input  logic [DM_TYPE_W-1:0] cpu_type,
  output logic                 cpu_gnt,
  output logic                 cpu_rvalid,
  output logic [AW-1:0]        cpu_rdata,
  input  logic                 dbg_req,
  input  logic                 dbg_we,
  input  logic [AW-1:0]        dbg_addr,
  input  logic [AW-1:0]        dbg_wdata,
  input  logic [DM_TYPE_W-1:0] dbg_type,
  output logic                 dbg_gnt,
  output logic                 dbg_rvalid,
  output logic [AW-1:0]        dbg_rdata,
  output logic                 dm_we,
  output logic [AW-1:0]        dm_addr,
  output logic [AW-1:0]        dm_din,
  output logic [DM_TYPE_W-1:0] dm_type,
  input  logic [AW-1:0]        dm_dout
);

  localparam int              CW       = wait_cnt_w(DBG_WAIT_MAX);
  localparam logic [CW-1:0]   WAIT_MAX = CW'(DBG_WAIT_MAX);

  logic [CW-1:0]        wait_q, wait_d;
  logic                 force_dbg, pick_cpu, pick_dbg;

  logic                 vld_p1_q, vld_p1_d;
  logic                 we_p1_q, we_p1_d;
  logic [AW-1:0]        addr_p1_q, addr_p1_d;
  logic [AW-1:0]        wdata_p1_q, wdata_p1_d;
  logic [DM_TYPE_W-1:0] type_p1_q, type_p1_d;
  dm_owner_e            own_p1_q, own_p1_d;

  logic                 acc_live, rd_fire;
  logic                 cpu_rvalid_p2_q, cpu_rvalid_p2_d;
  logic                 dbg_rvalid_p2_q, dbg_rvalid_p2_d;
  logic [AW-1:0]        cpu_rdata_q, dbg_rdata_q;

  // ---- stage 0: arbitration and debug starvation counter
  assign force_dbg = (wait_q == WAIT_MAX);

  dm_arb_pick u_pick (
    .cpu_req_i (cpu_req),
    .dbg_req_i (dbg_req),
    .force_i   (force_dbg),
    .cpu_gnt_o (pick_cpu),
    .dbg_gnt_o (pick_dbg)
  );

  assign cpu_gnt = pick_cpu & ~reset;
  assign dbg_gnt = pick_dbg & ~reset;

  always_comb begin
    wait_d = '0;
    if (dbg_req && !dbg_gnt) begin
      wait_d = force_dbg ? wait_q : wait_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_q <= '0;
    end else begin
      wait_q <= wait_d;
    end
  end

  always_comb begin
    vld_p1_d = cpu_gnt | dbg_gnt;
    if (dbg_gnt) begin
      we_p1_d    = dbg_we;
      addr_p1_d  = dbg_addr;
      wdata_p1_d = dbg_wdata;
      type_p1_d  = dbg_type;
      own_p1_d   = OWN_DBG;
    end else begin
      we_p1_d    = cpu_we;
      addr_p1_d  = cpu_addr;
      wdata_p1_d = cpu_wdata;
      type_p1_d  = cpu_type;
      own_p1_d   = OWN_CPU;
    end
  end

  // ---- stage 1: access stage drives the memory
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1_q <= 1'b0;
    end else begin
      vld_p1_q <= vld_p1_d;
    end
  end

  always_ff @(posedge clk) begin
    if (vld_p1_d) begin
      we_p1_q    <= we_p1_d;
      addr_p1_q  <= addr_p1_d;
      wdata_p1_q <= wdata_p1_d;
      type_p1_q  <= type_p1_d;
      own_p1_q   <= own_p1_d;
    end
  end

  // Reset kills the access combinationally so an in-flight write never reaches memory.
  assign acc_live = vld_p1_q & ~reset;
  assign rd_fire  = acc_live & ~we_p1_q;

  assign dm_we   = acc_live & we_p1_q;
  assign dm_addr = acc_live ? addr_p1_q  : '0;
  assign dm_din  = acc_live ? wdata_p1_q : '0;
  assign dm_type = acc_live ? type_p1_q  : '0;

  always_comb begin
    cpu_rvalid_p2_d = rd_fire & (own_p1_q == OWN_CPU);
    dbg_rvalid_p2_d = rd_fire & (own_p1_q == OWN_DBG);
  end

  // ---- stage 2: read response, per-port data held until the next response
  always_ff @(posedge clk) begin
    if (reset) begin
      cpu_rvalid_p2_q <= 1'b0;
      dbg_rvalid_p2_q <= 1'b0;
      cpu_rdata_q     <= '0;
      dbg_rdata_q     <= '0;
    end else begin
      cpu_rvalid_p2_q <= cpu_rvalid_p2_d;
      dbg_rvalid_p2_q <= dbg_rvalid_p2_d;
      if (cpu_rvalid_p2_d) cpu_rdata_q <= dm_dout;
      if (dbg_rvalid_p2_d) dbg_rdata_q <= dm_dout;
    end
  end

  assign cpu_rvalid = cpu_rvalid_p2_q & ~reset;
  assign dbg_rvalid = dbg_rvalid_p2_q & ~reset;
  assign cpu_rdata  = reset ? '0 : cpu_rdata_q;
  assign dbg_rdata  = reset ? '0 : dbg_rdata_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// Self-checking bench for dm_arbiter: vector table plus directed sequences, scoreboarded responses.
module tb_dm_arbiter;
  import pipeline_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we, dbg_req, dbg_we;
  logic [31:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;
  logic [2:0]  cpu_type, dbg_type;
  logic        cpu_gnt, cpu_rvalid, dbg_gnt, dbg_rvalid;
  logic [31:0] cpu_rdata, dbg_rdata;
  logic        dm_we;
  logic [31:0] dm_addr, dm_din, dm_dout;
  logic [2:0]  dm_type;

  dm_arbiter #(.DBG_WAIT_MAX(8), .AW(32)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_type(cpu_type), .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_type(dbg_type), .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .dm_we(dm_we), .dm_addr(dm_addr), .dm_din(dm_din), .dm_type(dm_type), .dm_dout(dm_dout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Data memory: combinational read, write on the clock edge ending the access cycle.
  logic [31:0] mem [256];
  always @(posedge clk) begin
    if (cyc == 0) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'hA500_0000 | i;
      mem[8] <= 32'h1234_5678;
    end else if (dm_we) begin
      mem[dm_addr[9:2]] <= dm_din;
    end
  end
  assign dm_dout = mem[dm_addr[9:2]];

  logic [31:0] ref_mem [256];

  typedef struct {
    logic        rst;
    logic        cr, cw;
    logic [31:0] ca, cd;
    logic        dr, dw;
    logic [31:0] da, dd;
    logic        ecg, edg;
  } vec_t;

  typedef struct { int due; logic port; logic [31:0] data; } rsp_t;
  typedef struct { int due; logic [31:0] addr; logic [31:0] data; } wr_t;

  rsp_t rq[$];
  wr_t  wq[$];
  int   n_cmp = 0;
  int   n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic cr, input logic cw, input logic [31:0] ca,
                              input logic [31:0] cd, input logic dr, input logic dw,
                              input logic [31:0] da, input logic [31:0] dd,
                              input logic ecg, input logic edg);
    vec_t v;
    v.rst = 1'b0;
    v.cr = cr; v.cw = cw; v.ca = ca; v.cd = cd;
    v.dr = dr; v.dw = dw; v.da = da; v.dd = dd;
    v.ecg = ecg; v.edg = edg;
    return v;
  endfunction

  task automatic track(input logic port, input logic we, input logic [31:0] a, input logic [31:0] d);
    wr_t  w;
    rsp_t r;
    if (we) begin
      ref_mem[a[9:2]] = d;
      w.due = cyc + 1; w.addr = a; w.data = d;
      wq.push_back(w);
    end else begin
      r.due = cyc + 2; r.port = port; r.data = ref_mem[a[9:2]];
      rq.push_back(r);
    end
  endtask

  // One clock cycle: drive after the edge, check grants mid-cycle, log expected work.
  task automatic run_vec(input vec_t v, input bit trk);
    @(posedge clk); #1;
    reset   = v.rst;
    cpu_req = v.cr; cpu_we = v.cw; cpu_addr = v.ca; cpu_wdata = v.cd;
    dbg_req = v.dr; dbg_we = v.dw; dbg_addr = v.da; dbg_wdata = v.dd;
    @(negedge clk);
    chk("cpu_gnt", {31'b0, cpu_gnt}, {31'b0, v.ecg});
    chk("dbg_gnt", {31'b0, dbg_gnt}, {31'b0, v.edg});
    if (trk && v.ecg) track(1'b0, v.cw, v.ca, v.cd);
    if (trk && v.edg) track(1'b1, v.dw, v.da, v.dd);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) run_vec(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b1);
  endtask

  // Response / memory-strobe monitor against the scoreboard queues.
  rsp_t e;
  always @(negedge clk) begin
    chk("one_grant", {31'b0, cpu_gnt & dbg_gnt}, 32'd0);
    if (wq.size() > 0 && wq[0].due == cyc) begin
      chk("dm_we", {31'b0, dm_we}, 32'd1);
      chk("dm_addr", dm_addr, wq[0].addr);
      chk("dm_din", dm_din, wq[0].data);
      chk("dm_type", {29'b0, dm_type}, {29'b0, DM_WORD});
      void'(wq.pop_front());
    end else if (dm_we) begin
      chk("dm_we_spurious", {31'b0, dm_we}, 32'd0);
    end
    if (rq.size() > 0 && rq[0].due == cyc) begin
      e = rq.pop_front();
      chk("cpu_rvalid", {31'b0, cpu_rvalid}, {31'b0, e.port == 1'b0});
      chk("dbg_rvalid", {31'b0, dbg_rvalid}, {31'b0, e.port == 1'b1});
      chk("rdata", e.port ? dbg_rdata : cpu_rdata, e.data);
    end else if (cpu_rvalid || dbg_rvalid) begin
      chk("rvalid_spurious", {30'b0, cpu_rvalid, dbg_rvalid}, 32'd0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  vec_t tbl[12];
  vec_t v;

  initial begin
    reset = 1'b1;
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0; cpu_type = DM_WORD;
    dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0; dbg_type = DM_WORD;
    for (int i = 0; i < 256; i++) ref_mem[i] = 32'hA500_0000 | i;
    ref_mem[8] = 32'h1234_5678;

    tbl[0]  = mk(0, 0, 32'h00, 0,             0, 0, 32'h00, 0,             0, 0);
    tbl[1]  = mk(1, 0, 32'h00, 0,             0, 0, 32'h00, 0,             1, 0);
    tbl[2]  = mk(0, 0, 32'h00, 0,             1, 0, 32'h04, 0,             0, 1);
    tbl[3]  = mk(1, 0, 32'h08, 0,             1, 0, 32'h0C, 0,             1, 0);
    tbl[4]  = mk(0, 0, 32'h00, 0,             1, 0, 32'h0C, 0,             0, 1);
    tbl[5]  = mk(1, 1, 32'h30, 32'hCAFEF00D,  0, 0, 32'h00, 0,             1, 0);
    tbl[6]  = mk(0, 0, 32'h00, 0,             1, 1, 32'h34, 32'h55AA55AA,  0, 1);
    tbl[7]  = mk(1, 0, 32'h30, 0,             0, 0, 32'h00, 0,             1, 0);
    tbl[8]  = mk(1, 1, 32'h38, 32'h01020304,  1, 0, 32'h34, 0,             1, 0);
    tbl[9]  = mk(0, 0, 32'h00, 0,             1, 0, 32'h34, 0,             0, 1);
    tbl[10] = mk(1, 0, 32'h38, 0,             0, 0, 32'h00, 0,             1, 0);
    tbl[11] = mk(0, 0, 32'h00, 0,             0, 0, 32'h00, 0,             0, 0);

    // Reset with both requesters active: nothing may be granted or driven.
    for (int i = 0; i < 3; i++) begin
      v = mk(1, 1, 32'h10, 32'hFFFF_FFFF, 1, 1, 32'h14, 32'hFFFF_FFFF, 0, 0);
      v.rst = 1'b1;
      run_vec(v, 1'b0);
      chk("rst_dm_we", {31'b0, dm_we}, 32'd0);
      chk("rst_dm_addr", dm_addr, 32'd0);
      chk("rst_dm_din", dm_din, 32'd0);
      chk("rst_rvalid", {30'b0, cpu_rvalid, dbg_rvalid}, 32'd0);
      chk("rst_cpu_rdata", cpu_rdata, 32'd0);
    end

    for (int i = 0; i < 12; i++) run_vec(tbl[i], 1'b1);
    idle(2);

    // Write then read-after-write to the same word.
    run_vec(mk(1, 1, 32'h10, 32'hDEADBEEF, 0, 0, 0, 0, 1, 0), 1'b1);
    run_vec(mk(1, 0, 32'h10, 0,            0, 0, 0, 0, 1, 0), 1'b1);
    idle(3);
    chk("cpu_rdata_hold", cpu_rdata, 32'hDEADBEEF);

    // Starved debug: forced through on the 9th cycle, CPU served right after.
    for (int i = 1; i <= 9; i++)
      run_vec(mk(1, 0, 32'h40, 0, 1, 0, 32'h20, 0, i != 9, i == 9), 1'b1);
    run_vec(mk(1, 0, 32'h44, 0, 0, 0, 0, 0, 1, 0), 1'b1);
    idle(3);

    // Debug-only read of preloaded word; CPU data must not move.
    run_vec(mk(0, 0, 0, 0, 1, 0, 32'h20, 0, 0, 1), 1'b1);
    idle(3);
    chk("dbg_rdata_0x20", dbg_rdata, 32'h1234_5678);
    chk("cpu_rdata_kept", cpu_rdata, 32'hA500_0011);

    // Write granted, then reset next cycle: the write must be dropped.
    run_vec(mk(1, 1, 32'h10, 32'h0BADF00D, 0, 0, 0, 0, 1, 0), 1'b0);
    for (int i = 0; i < 2; i++) begin
      v = mk(1, 0, 32'h10, 0, 0, 0, 0, 0, 0, 0);
      v.rst = 1'b1;
      run_vec(v, 1'b0);
      chk("rst_mid_dm_we", {31'b0, dm_we}, 32'd0);
      chk("rst_mid_rdata", cpu_rdata, 32'd0);
    end
    chk("mem_unchanged", mem[4], 32'hDEADBEEF);
    run_vec(mk(1, 0, 32'h10, 0, 0, 0, 0, 0, 1, 0), 1'b1);
    idle(3);

    // Alternating single-requester reads.
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) run_vec(mk(1, 0, 32'h40 + 4 * i, 0, 0, 0, 0, 0, 1, 0), 1'b1);
      else            run_vec(mk(0, 0, 0, 0, 1, 0, 32'h40 + 4 * i, 0, 0, 1), 1'b1);
    end
    idle(4);

    chk("rsp_queue_drained", rq.size(), 32'd0);
    chk("wr_queue_drained", wq.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
